// File: rtl/vga_pkg.sv
// Shared constants and encodings for the VGA pixel fetch slice.
package vga_pkg;

  localparam int HD    = 640;
  localparam int VD    = 480;
  localparam int PIX_W = 12;

  // Idle level of the active-low hsync/vsync lines.
  localparam logic SYNC_IDLE = 1'b1;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } scroll_dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } scroll_state_e;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset to a per-bit value.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Pixel fetch: maps screen position to a tiled image-ROM address and realigns
// syncs/valid to the ROM latency. Define VGA_PIXEL_FETCH_SCROLL_EN for frame scrolling.
//
// state | meaning
// IDLE  | no scroll requested
// ARMED | scroll_en seen on one frame start, offsets held
// RUN   | offsets step one texel per frame start while scroll_en stays high
module vga_pixel_fetch #(
  parameter int IMG_LOG2   = 6,
  parameter int SCALE_LOG2 = 2,
  parameter int MEM_LAT    = 1,
  parameter int PIX_W      = vga_pkg::PIX_W
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic [9:0]            h_cnt,
  input  logic [9:0]            v_cnt,
  output logic [2*IMG_LOG2-1:0] rom_addr,
  input  logic [PIX_W-1:0]      rom_data,
  input  logic                  scroll_en,
  input  logic [1:0]            scroll_dir,
  output logic [PIX_W-1:0]      pixel_out,
  output logic                  hsync_out,
  output logic                  vsync_out
);

  import vga_pkg::*;

  localparam int AW = 2 * IMG_LOG2;
  localparam logic [2:0] DL_RST = {1'b0, SYNC_IDLE, SYNC_IDLE};

  logic [IMG_LOG2-1:0] x_off;
  logic [IMG_LOG2-1:0] y_off;

`ifdef VGA_PIXEL_FETCH_SCROLL_EN
  localparam logic [IMG_LOG2-1:0] OFF_ONE = IMG_LOG2'(1);

  scroll_state_e       state_q;
  logic [IMG_LOG2-1:0] x_off_q;
  logic [IMG_LOG2-1:0] y_off_q;
  logic                vsync_prev_q;
  logic                fs;

  assign fs = vsync_prev_q & ~vsync_in;

  // Offsets only move on frame start so a frame is never drawn with two offsets.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= IDLE;
      x_off_q      <= '0;
      y_off_q      <= '0;
      vsync_prev_q <= SYNC_IDLE;
    end else begin
      vsync_prev_q <= vsync_in;
      if (fs) begin
        unique case (state_q)
          IDLE:  if (scroll_en) state_q <= ARMED;
          ARMED: state_q <= scroll_en ? RUN : IDLE;
          RUN: begin
            if (!scroll_en) begin
              state_q <= IDLE;
            end else begin
              unique case (scroll_dir)
                DIR_RIGHT: x_off_q <= x_off_q - OFF_ONE;
                DIR_LEFT:  x_off_q <= x_off_q + OFF_ONE;
                DIR_DOWN:  y_off_q <= y_off_q - OFF_ONE;
                DIR_UP:    y_off_q <= y_off_q + OFF_ONE;
                default:   x_off_q <= x_off_q;
              endcase
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign x_off = x_off_q;
  assign y_off = y_off_q;
`else
  logic unused_scroll;

  assign unused_scroll = ^{scroll_en, scroll_dir};
  assign x_off = '0;
  assign y_off = '0;
`endif

  // Stage A: texel coordinates; the IMG_LOG2-bit sums wrap, which tiles the image.
  logic [AW-1:0]       rom_addr_q;
  logic [AW-1:0]       rom_addr_d;
  logic [IMG_LOG2-1:0] tx;
  logic [IMG_LOG2-1:0] ty;
  logic                unused_cnt;

  assign unused_cnt = ^{h_cnt, v_cnt};

  always_comb begin
    tx         = h_cnt[SCALE_LOG2 +: IMG_LOG2] + x_off;
    ty         = v_cnt[SCALE_LOG2 +: IMG_LOG2] + y_off;
    rom_addr_d = {ty, tx};
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      rom_addr_q <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
    end
  end

  assign rom_addr = rom_addr_q;

  // Stage B: capture ROM data in the same cycle the delayed valid/syncs emerge.
  logic [PIX_W-1:0] pix_q;
  logic [PIX_W-1:0] pix_d;
  logic [2:0]       dl_out;

  always_comb begin
    pix_d = rom_data;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (MEM_LAT + 2),
    .RST_VAL (DL_RST)
  ) u_sync_dly (
    .pclk  (pclk),
    .reset (reset),
    .din   ({valid_in, hsync_in, vsync_in}),
    .dout  (dl_out)
  );

  // Both operands are flops, so the blanking gate adds no stale-pixel path after reset.
  assign pixel_out = dl_out[2] ? pix_q : '0;
  assign hsync_out = dl_out[1];
  assign vsync_out = dl_out[0];

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch against a frame-level reference model.
module tb_vga_pixel_fetch;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic [11:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic        scroll_en = 1'b0;
  logic [1:0]  scroll_dir = '0;
  logic [11:0] pixel_out;
  logic        hsync_out;
  logic        vsync_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] rom_mem [4096];

  // Reference state: offsets and how many consecutive frame starts saw scroll_en.
  int x_off_m = 0;
  int y_off_m = 0;
  int run_m   = 0;
  bit vs_prev_m = 1'b1;

  // History of accepted inputs, index 0 newest.
  logic [11:0] h_addr [3];
  bit          h_val  [3];
  bit          h_hs   [3];
  bit          h_vs   [3];

  logic [11:0] addr_exp;
  logic [11:0] pix_exp;
  bit          hs_exp;
  bit          vs_exp;

  vga_pixel_fetch dut (
    .pclk       (pclk),
    .reset      (reset),
    .valid_in   (valid_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .scroll_en  (scroll_en),
    .scroll_dir (scroll_dir),
    .pixel_out  (pixel_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out)
  );

  always #20 pclk = ~pclk;

  // One-cycle ROM.
  always @(posedge pclk) rom_data <= rom_mem[rom_addr];

  function automatic logic [11:0] model_addr(input int h, input int v);
    int tx, ty;
    tx = ((h / 4) + x_off_m) % 64;
    ty = ((v / 4) + y_off_m) % 64;
    return 12'(ty * 64 + tx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit do_chk);
    logic [11:0] a;
    bit fs;
    a  = model_addr(int'(h_cnt), int'(v_cnt));
    fs = vs_prev_m && !vsync_in;
    @(posedge pclk);
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        h_addr[i] = '0; h_val[i] = 1'b0; h_hs[i] = 1'b1; h_vs[i] = 1'b1;
      end
      addr_exp = '0; pix_exp = '0; hs_exp = 1'b1; vs_exp = 1'b1;
      x_off_m = 0; y_off_m = 0; run_m = 0; vs_prev_m = 1'b1;
    end else begin
      for (int i = 2; i > 0; i--) begin
        h_addr[i] = h_addr[i-1]; h_val[i] = h_val[i-1];
        h_hs[i] = h_hs[i-1]; h_vs[i] = h_vs[i-1];
      end
      h_addr[0] = a; h_val[0] = valid_in; h_hs[0] = hsync_in; h_vs[0] = vsync_in;
      addr_exp = a;
      pix_exp  = h_val[2] ? rom_mem[h_addr[2]] : 12'h000;
      hs_exp   = h_hs[2];
      vs_exp   = h_vs[2];
      vs_prev_m = vsync_in;
`ifdef VGA_PIXEL_FETCH_SCROLL_EN
      if (fs) begin
        if (scroll_en) begin
          if (run_m < 3) run_m++;
          if (run_m == 3) begin
            case (scroll_dir)
              2'd0: x_off_m = (x_off_m + 63) % 64;
              2'd1: x_off_m = (x_off_m + 1) % 64;
              2'd2: y_off_m = (y_off_m + 63) % 64;
              default: y_off_m = (y_off_m + 1) % 64;
            endcase
          end
        end else begin
          run_m = 0;
        end
      end
`else
      if (fs) run_m = 0;
`endif
    end
    #1;
    if (do_chk) begin
      chk("rom_addr", 32'(rom_addr), 32'(addr_exp));
      chk("pixel_out", 32'(pixel_out), 32'(pix_exp));
      chk("hsync_out", 32'(hsync_out), 32'(hs_exp));
      chk("vsync_out", 32'(vsync_out), 32'(vs_exp));
    end
  endtask

  task automatic frame_start(input int n);
    for (int i = 0; i < n; i++) begin
      vsync_in = 1'b1; h_cnt = 10'($urandom_range(0, 799)); tick(1);
      vsync_in = 1'b0; tick(1);
      vsync_in = 1'b1; tick(1);
    end
  endtask

  initial begin
    int xs;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 12'($urandom) | 12'h001;

    // Reset state.
    reset = 1'b1;
    tick(1); tick(1); tick(1);
    chk("reset_pixel", 32'(pixel_out), 32'h0);
    chk("reset_hsync", 32'(hsync_out), 32'h1);

    // Latency: h=5, v=0 -> address 1 next cycle, pixel 3 cycles after input.
    reset = 1'b0; h_cnt = 10'd5; v_cnt = 10'd0; valid_in = 1'b1; hsync_in = 1'b0;
    tick(1);
    chk("lat_addr", 32'(rom_addr), 32'h001);
    hsync_in = 1'b1; h_cnt = 10'd6; tick(1);
    tick(1);
    chk("lat_pixel", 32'(pixel_out), 32'(rom_mem[1]));
    chk("lat_hsync", 32'(hsync_out), 32'h0);

    // Tiling corner.
    h_cnt = 10'd639; v_cnt = 10'd479; tick(1);
    chk("tile_addr", 32'(rom_addr), 32'hDDF);

    // Blanking across the horizontal porch.
    for (int h = 630; h < 800; h++) begin
      h_cnt = 10'(h); valid_in = (h < 640); hsync_in = !(h >= 656 && h < 752);
      tick(1);
    end

    // Random scan with occasional resets and scroll activity.
    for (int i = 0; i < 1500; i++) begin
      h_cnt      = 10'($urandom_range(0, 799));
      v_cnt      = 10'($urandom_range(0, 524));
      valid_in   = (h_cnt < 640) && (v_cnt < 480);
      hsync_in   = 1'($urandom);
      if ($urandom_range(0, 15) == 0) vsync_in = ~vsync_in;
      scroll_en  = ($urandom_range(0, 3) != 0);
      scroll_dir = 2'($urandom);
      reset      = ($urandom_range(0, 199) == 0);
      tick(1);
    end

    // Directed scroll: left, three frame starts then wrap around 63 -> 0.
    reset = 1'b1; tick(1); reset = 1'b0;
    scroll_en = 1'b1; scroll_dir = 2'd1; valid_in = 1'b1; v_cnt = 10'd0;
    frame_start(3);
    h_cnt = 10'd0; tick(1);
`ifdef VGA_PIXEL_FETCH_SCROLL_EN
    xs = 1;
`else
    xs = 0;
`endif
    chk("scroll_x1", 32'(rom_addr), 32'(xs));
    frame_start(62);
    h_cnt = 10'd0; tick(1);
    chk("scroll_x63", 32'(rom_addr), 32'(xs * 63));
    frame_start(1);
    h_cnt = 10'd0; tick(1);
    chk("scroll_wrap", 32'(rom_addr), 32'h0);

    // Direction change mid-frame, then drop enable before frame start.
    scroll_dir = 2'd0;
    for (int i = 0; i < 10; i++) begin
      h_cnt = 10'($urandom_range(0, 639)); v_cnt = 10'($urandom_range(0, 479));
      if (i == 5) scroll_dir = 2'd2;
      tick(1);
    end
    scroll_en = 1'b0; tick(1);
    frame_start(2);
    scroll_en = 1'b1; scroll_dir = 2'd3;
    frame_start(4);
    h_cnt = 10'd0; v_cnt = 10'd0; tick(1);

    // Reset with pixels in flight.
    for (int i = 0; i < 4; i++) begin
      h_cnt = 10'(i * 4); valid_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0; tick(1);
    end
    reset = 1'b1; tick(1);
    chk("midrst_pixel", 32'(pixel_out), 32'h0);
    chk("midrst_vsync", 32'(vsync_out), 32'h1);
    reset = 1'b0; tick(1); tick(1); tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
